if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Directly upstream of the ID-stage hazard logic. Consumes its Stall_PC / Stall_ID outputs and the ID-stage branch/jump redirect.
- Produces the instruction and PC+4 that ID decodes and feeds back into hazard detection.
- Owns the PC register, redirect/flush handling and a stall watchdog.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction injected into IF/ID on flush or reset (sll $0,$0,0).
- MAX_STALL, 8, consecutive Stall_PC cycles before Stall_Err sets; legal range 1..255.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Stall_PC  in  1  hold PC (from hazard detection)
- Stall_ID  in  1  hold IF/ID register (from hazard detection)
- Branch_Taken  in  1  ID-stage branch/jump resolved taken
- Branch_Target  in  32  redirect address from ID
- IMem_Addr  out  32  current PC to instruction memory (combinational read)
- IMem_Instr  in  32  instruction word at IMem_Addr, same cycle
- ID_Instr  out  32  IF/ID instruction
- ID_PCPlus4  out  32  IF/ID PC+4
- ID_Valid  out  1  IF/ID holds a real instruction (0 = bubble)
- Stall_Err  out  1  sticky watchdog flag

Behaviour:
- Reset asserted (async, any cycle, including mid-stall or mid-redirect):
  - PC = RESET_PC, ID_Instr = NOP_INSTR, ID_PCPlus4 = 0, ID_Valid = 0.
  - Stall counter = 0, Stall_Err = 0.
- IMem_Addr = PC, combinational. Fetch latency is one cycle: instruction at PC appears on ID_Instr on the next edge.
- PC update, priority high to low:
  1. Stall_PC = 1: hold. Branch_Taken is ignored because the ID operands are stale.
  2. Branch_Taken = 1: PC <= {Branch_Target[31:2], 2'b00}.
  3. Otherwise: PC <= PC + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- IF/ID update, priority high to low:
  1. Stall_ID = 1: hold all three fields.
  2. Branch_Taken = 1: flush. ID_Instr <= NOP_INSTR, ID_PCPlus4 <= 0, ID_Valid <= 0. No delay slot.
  3. Otherwise: ID_Instr <= IMem_Instr, ID_PCPlus4 <= PC + 4, ID_Valid <= 1.
- Stall_PC and Stall_ID are applied independently.
  - Stall_PC = 1 with Stall_ID = 0 re-presents the same PC next cycle, so the instruction is duplicated; this is legal but never produced by hazard detection.
  - Stall_ID = 1 with Stall_PC = 0 drops the fetched word.
  - Both cases are covered by assertions, not functional requirements.
- First edge after reset deassert: IF/ID loads the word at RESET_PC with ID_Valid = 1, unless a stall is present.
- Watchdog:
  - 8-bit counter increments on each cycle with Stall_PC = 1 and clears on any cycle with Stall_PC = 0.
  - Saturates at MAX_STALL.
  - Stall_Err sets on the edge where the counter reaches MAX_STALL and stays set until reset.
- Outputs are registered, except IMem_Addr, which is combinational from the PC register.

Optional Feature:
- Macro: IF_STAGE_PERF_CNT_EN.
- When defined, adds output Stall_Cycles (32-bit) and output Flush_Count (32-bit).
  - Both are free-running, reset to 0 and wrap at 2^32.
  - Stall_Cycles increments on every cycle with Stall_PC = 1.
  - Flush_Count increments on each cycle in which an IF/ID flush is actually applied (Branch_Taken = 1 and Stall_ID = 0).
- When not defined: both ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Package ece369_pipe_pkg:
  - NOP_INSTR and RESET_PC defaults.
  - PC width constant (32).
  - Struct if_id_t {instr, pc_plus4, valid}, reused later by the ID/EX register.
- One sub-module, if_pc_reg: PC register with stall/redirect priority and the +4 incrementer.
- IF/ID register, watchdog and optional counters stay in if_stage.

Test Plan:
- Reset, then release with IMem returning 32'h2008_0005 at address 0 → IMem_Addr sequence 0, 4, 8. After the first edge: ID_Instr = 32'h2008_0005, ID_PCPlus4 = 4, ID_Valid = 1.
- Stall_PC = Stall_ID = 1 for 2 cycles at PC = 8 → IMem_Addr stays 8 and IF/ID is unchanged for 2 cycles. Fetch resumes at 12 after release.
- Branch_Taken = 1, Branch_Target = 32'h0000_0043, no stall → next PC = 32'h40. IF/ID = NOP, PCPlus4 = 0, Valid = 0 for one cycle, then the word at 32'h40.
- Branch_Taken = 1 together with Stall_PC = Stall_ID = 1 → PC and IF/ID held, redirect ignored. Deassert the stall with Branch_Taken still 1 → redirect taken.
- Stall_PC held for MAX_STALL = 8 cycles → Stall_Err = 1 after the 8th edge and stays 1 after the stall clears. Holding for 7 cycles leaves it 0.
- Async reset pulsed mid-cycle during a redirect at PC = 32'hFFFF_FFFC → all outputs return to reset values immediately without waiting for Clock. Separately, with no stall, PC = 32'hFFFF_FFFC wraps to 0.

Source files
------------

// File: rtl/ece369_pipe_pkg.sv
// rtl/ece369_pipe_pkg.sv - shared pipeline constants and IF/ID register layout
package ece369_pipe_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0]     NOP_INSTR_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// rtl/if_pc_reg.sv - program counter with stall/redirect priority and +4 incrementer
module if_pc_reg
    import ece369_pipe_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + PC_W'(4);

    // A stall wins over a redirect: the ID operands behind the branch are stale.
    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            pc_d = redirect ? word_align(target) : pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - IF stage, IF/ID register and stall watchdog; IF_STAGE_PERF_CNT_EN adds perf counters
module if_stage
    import ece369_pipe_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF,
    parameter int              MAX_STALL = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Stall_PC,
    input  logic            Stall_ID,
    input  logic            Branch_Taken,
    input  logic [PC_W-1:0] Branch_Target,
    output logic [PC_W-1:0] IMem_Addr,
    input  logic [31:0]     IMem_Instr,
    output logic [31:0]     ID_Instr,
    output logic [PC_W-1:0] ID_PCPlus4,
    output logic            ID_Valid,
    output logic            Stall_Err
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]     Stall_Cycles,
    output logic [31:0]     Flush_Count
`endif
);

    localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus4;

    if_id_t     if_id_q,     if_id_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       stall_err_q, stall_err_d;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (Clock),
        .rst_n    (Reset),
        .stall    (Stall_PC),
        .redirect (Branch_Taken),
        .target   (Branch_Target),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    assign IMem_Addr  = pc;
    assign ID_Instr   = if_id_q.instr;
    assign ID_PCPlus4 = if_id_q.pc_plus4;
    assign ID_Valid   = if_id_q.valid;
    assign Stall_Err  = stall_err_q;

    // No delay slot: a taken branch squashes the word fetched alongside it.
    always_comb begin
        if_id_d = if_id_q;
        if (!Stall_ID) begin
            if (Branch_Taken) begin
                if_id_d = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
            end else begin
                if_id_d = '{instr: IMem_Instr, pc_plus4: pc_plus4, valid: 1'b1};
            end
        end
    end

    always_comb begin
        stall_cnt_d = 8'd0;
        stall_err_d = stall_err_q;
        if (Stall_PC) begin
            stall_cnt_d = (stall_cnt_q < MAX_STALL_C) ? stall_cnt_q + 8'd1 : stall_cnt_q;
            if (stall_cnt_d == MAX_STALL_C) begin
                stall_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            if_id_q     <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
            stall_cnt_q <= 8'd0;
            stall_err_q <= 1'b0;
        end else begin
            if_id_q     <= if_id_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q,  flush_count_d;

    always_comb begin
        stall_cycles_d = Stall_PC ? stall_cycles_q + 32'd1 : stall_cycles_q;
        flush_count_d  = (Branch_Taken && !Stall_ID) ? flush_count_q + 32'd1 : flush_count_q;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign Stall_Cycles = stall_cycles_q;
    assign Flush_Count  = flush_count_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized bench for if_stage against an architectural fetch model
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_pc, stall_id, br_taken;
    logic [31:0] br_target;
    logic [31:0] imem_addr, imem_instr;
    logic [31:0] id_instr, id_pcplus4;
    logic        id_valid, stall_err;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Architectural state the pipeline front end must present
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid, m_err;
    int          m_stall_run;

    always #5 clk = ~clk;

    if_stage dut (
        .Clock         (clk),
        .Reset         (rst_n),
        .Stall_PC      (stall_pc),
        .Stall_ID      (stall_id),
        .Branch_Taken  (br_taken),
        .Branch_Target (br_target),
        .IMem_Addr     (imem_addr),
        .IMem_Instr    (imem_instr),
        .ID_Instr      (id_instr),
        .ID_PCPlus4    (id_pcplus4),
        .ID_Valid      (id_valid),
        .Stall_Err     (stall_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h2008_0005;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always_comb imem_instr = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
        m_err = 1'b0; m_stall_run = 0;
    endtask

    // Applied once per rising edge using the inputs that were present before it
    task automatic model_edge();
        m_stall_run = stall_pc ? m_stall_run + 1 : 0;
        if (m_stall_run >= 8) m_err = 1'b1;
        if (!stall_id) begin
            if (br_taken) begin
                m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
            end else begin
                m_instr = mem_word(m_pc); m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
            end
        end
        if (!stall_pc) m_pc = br_taken ? (br_target & 32'hFFFF_FFFC) : m_pc + 32'd4;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("id_instr", id_instr, m_instr);
            chk("id_pcplus4", id_pcplus4, m_pp4);
            chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
            chk("stall_err", {31'd0, stall_err}, {31'd0, m_err});
        end
    end

    task automatic cyc(input logic sp, input logic si, input logic bt, input logic [31:0] tgt);
        stall_pc = sp; stall_id = si; br_taken = bt; br_target = tgt;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall_pc = 1'b0; stall_id = 1'b0; br_taken = 1'b0; br_target = 32'd0;
        model_reset();
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, imem_addr, 32'd0);
        chk({tag, "_instr"}, id_instr, 32'd0);
        chk({tag, "_pp4"}, id_pcplus4, 32'd0);
        chk({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
        chk({tag, "_err"}, {31'd0, stall_err}, 32'd0);
    endtask

    initial begin
        do_reset();
        chk_reset_vals("rst");

        // Fetch from reset vector
        cyc(0, 0, 0, 0);
        chk("first_instr", id_instr, 32'h2008_0005);
        chk("first_pp4", id_pcplus4, 32'd4);
        chk("first_valid", {31'd0, id_valid}, 32'd1);
        chk("first_addr", imem_addr, 32'd4);
        cyc(0, 0, 0, 0);
        chk("addr8", imem_addr, 32'd8);

        // Two-cycle full stall at PC 8
        repeat (2) begin
            cyc(1, 1, 0, 0);
            chk("stall_addr", imem_addr, 32'd8);
            chk("stall_pp4", id_pcplus4, 32'd8);
        end
        cyc(0, 0, 0, 0);
        chk("resume_addr", imem_addr, 32'd12);
        chk("resume_pp4", id_pcplus4, 32'd12);

        // Redirect with unaligned target
        cyc(0, 0, 1, 32'h0000_0043);
        chk("br_addr", imem_addr, 32'h40);
        chk("br_valid", {31'd0, id_valid}, 32'd0);
        chk("br_pp4", id_pcplus4, 32'd0);
        chk("br_instr", id_instr, 32'd0);
        cyc(0, 0, 0, 0);
        chk("br_tgt_pp4", id_pcplus4, 32'h44);
        chk("br_tgt_instr", id_instr, mem_word(32'h40));

        // Redirect masked by stall, then taken once the stall drops
        cyc(1, 1, 1, 32'h100);
        chk("brst_addr", imem_addr, 32'h44);
        chk("brst_valid", {31'd0, id_valid}, 32'd1);
        cyc(0, 0, 1, 32'h100);
        chk("brrel_addr", imem_addr, 32'h100);
        chk("brrel_valid", {31'd0, id_valid}, 32'd0);

        // Watchdog: 7 stalls is below threshold, 8 trips it
        do_reset();
        repeat (7) cyc(1, 1, 0, 0);
        chk("wd7", {31'd0, stall_err}, 32'd0);
        cyc(0, 0, 0, 0);
        repeat (7) cyc(1, 1, 0, 0);
        chk("wd_pre8", {31'd0, stall_err}, 32'd0);
        cyc(1, 1, 0, 0);
        chk("wd8", {31'd0, stall_err}, 32'd1);
        cyc(0, 0, 0, 0);
        chk("wd_sticky", {31'd0, stall_err}, 32'd1);

        // PC wrap at the top of the address space
        do_reset();
        cyc(0, 0, 1, 32'hFFFF_FFFF);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        chk("wrap_addr", imem_addr, 32'd0);
        chk("wrap_pp4", id_pcplus4, 32'd0);
        chk("wrap_valid", {31'd0, id_valid}, 32'd1);

        // Asynchronous reset mid-cycle during a redirect
        cyc(0, 0, 1, 32'hFFFF_FFFF);
        br_taken = 1'b1; br_target = 32'h200;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_vals("async");
        @(posedge clk);
        #1;
        chk_reset_vals("async_hold");
        br_taken = 1'b0;
        rst_n = 1'b1;

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            int r;
            logic [31:0] tgt;
            r = $urandom_range(0, 99);
            tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            cyc(r < 18, (r < 15) || (r >= 18 && r < 21), $urandom_range(0, 99) < 20, tgt);
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
